// File: rtl/mips_cpu_alu_muldiv.sv
// Execute-stage ALU for mips_cpu: single-cycle ALU ops, an iterative
// multiply/divide unit (one step per cycle) and architectural HI/LO.
`timescale 1ns/1ps
module mips_cpu_alu_muldiv #(
    parameter int WIDTH = 32,
    localparam int SA_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SA_W-1:0]  sa,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = SA_W + 1;

    typedef enum logic [4:0] {
        OP_AND   = 5'd0,  OP_OR    = 5'd1,  OP_ADD   = 5'd2,  OP_SUB   = 5'd3,
        OP_SLT   = 5'd4,  OP_XOR   = 5'd5,  OP_SLL   = 5'd6,  OP_SRL   = 5'd7,
        OP_SRA   = 5'd8,  OP_SLLV  = 5'd9,  OP_SRLV  = 5'd10, OP_SRAV  = 5'd11,
        OP_LUI   = 5'd12, OP_SLTU  = 5'd13, OP_PASSA = 5'd14, OP_PASSB = 5'd15,
        OP_MULT  = 5'd16, OP_MULTU = 5'd17, OP_DIV   = 5'd18, OP_DIVU  = 5'd19,
        OP_MTHI  = 5'd20, OP_MTLO  = 5'd21, OP_MFHI  = 5'd22, OP_MFLO  = 5'd23
    } op_e;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e state, state_nxt;

    logic                 accept, is_md_op, last_step;
    logic [WIDTH-1:0]     alu_res;
    logic                 op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]     abs_a, abs_b;

    // Iteration state: acc is the product high half / partial remainder,
    // mq the product low half / dividend-then-quotient, mag_op the
    // multiplicand or divisor magnitude.
    logic [WIDTH-1:0]     acc, mq, mag_op, a_lat;
    logic                 md_div, neg_q, neg_r, dvz;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]     acc_step, mq_step, hi_fin, lo_fin;
    logic [2*WIDTH-1:0]   prod, prod_fix;

    assign busy      = (state == S_RUN);
    assign accept    = start && (state == S_IDLE);
    assign is_md_op  = (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
    assign last_step = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));

    // Operand magnitudes; op[0] set means the unsigned variant.
    assign op_signed = ~op[0];
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign abs_a     = a_neg ? -a : a;
    assign abs_b     = b_neg ? -b : b;

    // State register for the mul/div sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state: idle until a mul/div is accepted, then run WIDTH steps.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && is_md_op) state_nxt = S_RUN;
            S_RUN:   if (last_step)          state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Single-cycle ALU result.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_ADD:   alu_res = a + b;
            OP_SUB:   alu_res = a - b;
            OP_SLT:   alu_res = WIDTH'($signed(a) < $signed(b));
            OP_XOR:   alu_res = a ^ b;
            OP_SLL:   alu_res = b << sa;
            OP_SRL:   alu_res = b >> sa;
            OP_SRA:   alu_res = $signed(b) >>> sa;
            OP_SLLV:  alu_res = b << a[SA_W-1:0];
            OP_SRLV:  alu_res = b >> a[SA_W-1:0];
            OP_SRAV:  alu_res = $signed(b) >>> a[SA_W-1:0];
            OP_LUI:   alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLTU:  alu_res = WIDTH'(a < b);
            OP_PASSA: alu_res = a;
            OP_PASSB: alu_res = b;
            OP_MTHI:  alu_res = a;
            OP_MTLO:  alu_res = a;
            OP_MFHI:  alu_res = hi;
            OP_MFLO:  alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    // One shift-add (multiply) or restoring-subtract (divide) step, plus
    // the sign fix-up applied on the final step.
    always_comb begin
        mul_sum   = {1'b0, acc} + {1'b0, mag_op};
        div_shift = {acc, mq[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_op};
        acc_step  = acc;
        mq_step   = mq;
        if (md_div) begin
            if (!div_diff[WIDTH]) begin
                acc_step = div_diff[WIDTH-1:0];
                mq_step  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = div_shift[WIDTH-1:0];
                mq_step  = {mq[WIDTH-2:0], 1'b0};
            end
        end else if (mq[0]) begin
            acc_step = mul_sum[WIDTH:1];
            mq_step  = {mul_sum[0], mq[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc[WIDTH-1:1]};
            mq_step  = {acc[0], mq[WIDTH-1:1]};
        end

        prod     = {acc_step, mq_step};
        prod_fix = neg_q ? -prod : prod;
        if (!md_div) begin
            hi_fin = prod_fix[2*WIDTH-1:WIDTH];
            lo_fin = prod_fix[WIDTH-1:0];
        end else if (dvz) begin
            hi_fin = a_lat;
            lo_fin = '1;
        end else begin
            hi_fin = neg_r ? -acc_step : acc_step;
            lo_fin = neg_q ? -mq_step  : mq_step;
        end
    end

    // Datapath and architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the iteration registers are reset along with the outputs so
        // an aborted operation leaves no stale state behind.
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            mq     <= '0;
            mag_op <= '0;
            a_lat  <= '0;
            md_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dvz    <= 1'b0;
            cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register
            // samples pre-edge values regardless of statement order.
            done <= 1'b0;
            if (accept && is_md_op) begin
                md_div <= op[1];
                acc    <= '0;
                mq     <= op[1] ? abs_a : abs_b;
                mag_op <= op[1] ? abs_b : abs_a;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dvz    <= (b == '0);
                a_lat  <= a;
                cnt    <= '0;
            end else if (accept) begin
                result <= alu_res;
                zero   <= (alu_res == '0);
                done   <= 1'b1;
                if (op == OP_MTHI) hi <= a;
                if (op == OP_MTLO) lo <= a;
            end else if (state == S_RUN) begin
                acc <= acc_step;
                mq  <= mq_step;
                cnt <= cnt + CNT_W'(1);
                if (last_step) begin
                    hi     <= hi_fin;
                    lo     <= lo_fin;
                    result <= lo_fin;
                    zero   <= (lo_fin == '0);
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_alu_muldiv.sv
// Directed bench for mips_cpu_alu_muldiv at WIDTH=32.
`timescale 1ns/1ps
module tb_mips_cpu_alu_muldiv;

    localparam int W    = 32;
    localparam int SA_W = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [4:0]    op;
    logic [W-1:0]  a, b;
    logic [SA_W-1:0] sa;
    logic [W-1:0]  result, hi, lo;
    logic          zero, done, busy;

    int n_cmp = 0;
    int n_err = 0;

    mips_cpu_alu_muldiv #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .sa     (sa),
        .result (result),
        .zero   (zero),
        .done   (done),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    // Present one request for one edge; returns 1 time unit after that edge.
    task automatic issue(input logic [4:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [SA_W-1:0] s);
        op = o; a = av; b = bv; sa = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic alu(input string tag, input logic [4:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [SA_W-1:0] s, input logic [W-1:0] exp);
        issue(o, av, bv, s);
        check({tag, " result"}, result, exp);
        check({tag, " zero"}, W'(zero), W'(exp == '0));
        check({tag, " done"}, W'(done), 1);
    endtask

    // Run a mul/div to completion, checking latency, busy span and hi/lo hold.
    // With hammer set, MTHI is requested on every busy cycle.
    task automatic run_md(input string tag, input logic [4:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input bit hammer);
        logic [W-1:0] hi0, lo0;
        int cyc, nbusy;
        bit moved;
        hi0 = hi; lo0 = lo; moved = 1'b0; nbusy = 0;
        issue(o, av, bv, '0);
        cyc = 1;
        while (!done && cyc < 40) begin
            if (busy) nbusy++;
            if (hi !== hi0 || lo !== lo0) moved = 1'b1;
            if (hammer) begin
                start = busy; op = 5'd20; a = 32'h1234_5678;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, W'(cyc), 33);
        check({tag, " busy cycles"}, W'(nbusy), 32);
        check({tag, " hi/lo hold"}, W'(moved), 0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " result"}, result, exp_lo);
        check({tag, " zero"}, W'(zero), W'(exp_lo == '0));
        check({tag, " busy end"}, W'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for 3 edges with a request pending.
        rst_n = 1'b0; start = 1'b1; op = 5'd2; a = 32'd1; b = 32'd1; sa = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst result", result, 0);
        check("rst zero", W'(zero), 1);
        check("rst busy", W'(busy), 0);
        check("rst done", W'(done), 0);
        check("rst hi", hi, 0);
        check("rst lo", lo, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops.
        alu("add", 5'd2, 32'h7FFF_FFFF, 32'h1, '0, 32'h8000_0000);
        @(posedge clk); #1;
        check("add hold result", result, 32'h8000_0000);
        check("add done pulse", W'(done), 0);
        alu("sub", 5'd3, 32'd5, 32'd5, '0, 32'h0);
        alu("and", 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00, '0, 32'h00F0_1200);
        alu("or",  5'd1, 32'hF0F0_1234, 32'h0FF0_FF00, '0, 32'hFFF0_FF34);
        alu("xor", 5'd5, 32'hF0F0_1234, 32'h0FF0_FF00, '0, 32'hFF00_ED34);
        alu("slt", 5'd4, 32'hFFFF_FFFF, 32'h1, '0, 32'h1);
        alu("sltu", 5'd13, 32'hFFFF_FFFF, 32'h1, '0, 32'h0);
        alu("sll", 5'd6, 32'h0, 32'h1, 5'd31, 32'h8000_0000);
        alu("srl", 5'd7, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000);
        alu("sra", 5'd8, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000);
        alu("srav", 5'd11, 32'h24, 32'h8000_0000, 5'd0, 32'hF800_0000);
        alu("lui", 5'd12, 32'h0, 32'h0000_ABCD, '0, 32'hABCD_0000);
        alu("pass a", 5'd14, 32'h1357_9BDF, 32'h2468_ACE0, '0, 32'h1357_9BDF);
        alu("pass b", 5'd15, 32'h1357_9BDF, 32'h2468_ACE0, '0, 32'h2468_ACE0);
        alu("unused", 5'd24, 32'h1357_9BDF, 32'h2468_ACE0, '0, 32'h0);

        // HI/LO moves.
        alu("mtlo", 5'd21, 32'hCAFE_F00D, 32'h0, '0, 32'hCAFE_F00D);
        check("mtlo lo", lo, 32'hCAFE_F00D);
        alu("mthi", 5'd20, 32'h0BAD_BEEF, 32'h0, '0, 32'h0BAD_BEEF);
        check("mthi hi", hi, 32'h0BAD_BEEF);
        alu("mflo", 5'd23, 32'h0, 32'h0, '0, 32'hCAFE_F00D);
        alu("mfhi", 5'd22, 32'h0, 32'h0, '0, 32'h0BAD_BEEF);

        // Multiply.
        run_md("mult", 5'd16, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_md("multu mthi", 5'd17, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 1'b1);
        alu("mflo in done", 5'd23, 32'h0, 32'h0, '0, 32'hFFFF_FFFE);

        // Divide.
        run_md("div neg", 5'd18, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        alu("mfhi in done", 5'd22, 32'h0, 32'h0, '0, 32'hFFFF_FFFF);
        run_md("div negdvsr", 5'd18, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
        run_md("div ovf", 5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_md("divu by 0", 5'd19, 32'd9, 32'd0, 32'h9, 32'hFFFF_FFFF, 1'b0);
        alu("mfhi dvz", 5'd22, 32'h0, 32'h0, '0, 32'h9);

        // Asynchronous reset in the middle of a divide.
        issue(5'd19, 32'd100, 32'd7, '0);
        repeat (9) @(posedge clk);
        #1;
        check("abort busy before", W'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", W'(busy), 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        check("abort result", result, 0);
        check("abort zero", W'(zero), 1);
        check("abort done", W'(done), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort no done", W'(done), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            check("post abort no done", W'(done | busy), 0);
        end
        run_md("divu fresh", 5'd19, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
